// File: rtl/proc_pkg.sv
// Shared processor constants: R-type decode fields, rstatus exception codes
// and the multiply/divide sequencer state encoding.
package proc_pkg;

    localparam logic [4:0] OPC_RTYPE   = 5'd0;
    localparam logic [4:0] ALUOP_MUL   = 5'd6;
    localparam logic [4:0] ALUOP_DIV   = 5'd7;

    localparam logic [4:0] RSTATUS_REG = 5'd30;

    // rstatus values; add/sub/addi share the same register convention
    localparam int ADD_EXC_CODE  = 1;
    localparam int ADDI_EXC_CODE = 2;
    localparam int SUB_EXC_CODE  = 3;
    localparam int MUL_EXC_CODE  = 4;
    localparam int DIV_EXC_CODE  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    function automatic logic f_is_md(input logic [31:0] ir);
        return (ir[31:27] == OPC_RTYPE) &&
               ((ir[6:2] == ALUOP_MUL) || (ir[6:2] == ALUOP_DIV));
    endfunction

endpackage

// File: rtl/multdiv_datapath.sv
// Shared shift-add multiplier / restoring divider, one step per cycle.
// r_hi is accumulator (mul) or remainder (div); r_lo shifts multiplier or dividend/quotient.
module multdiv_datapath #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic                 i_busy,
    input  logic                 i_is_div,
    input  logic [WIDTH-1:0]     i_mag_a,
    input  logic [WIDTH-1:0]     i_mag_b,
    input  logic                 i_neg,
    output logic                 o_done_step,
    output logic [2*WIDTH-1:0]   o_result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_b;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_cand;
    logic [WIDTH:0]     w_div_diff;
    logic [WIDTH-1:0]   w_hi_nxt;
    logic [WIDTH-1:0]   w_lo_nxt;
    logic [2*WIDTH-1:0] w_mag;

    // One iteration of the selected algorithm, plus final sign correction
    always_comb begin
        w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
        w_div_cand = {r_hi, r_lo[WIDTH-1]};
        w_div_diff = w_div_cand - {1'b0, r_b};
        if (r_is_div) begin
            // a clear borrow bit means the divisor fits: keep the difference
            if (!w_div_diff[WIDTH]) begin
                w_hi_nxt = w_div_diff[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_div_cand[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
            end
            w_mag = {{WIDTH{1'b0}}, w_lo_nxt};
        end else begin
            {w_hi_nxt, w_lo_nxt} = {w_mul_sum, r_lo[WIDTH-1:1]};
            w_mag = {w_hi_nxt, w_lo_nxt};
        end
        o_result = r_neg ? ({(2*WIDTH){1'b0}} - w_mag) : w_mag;
    end

    assign o_done_step = i_busy && (r_cnt == CW'(WIDTH - 1));

    // Operand load on start, then shift/step while busy
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hi     <= {WIDTH{1'b0}};
            r_lo     <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
        end else if (i_start) begin
            r_hi     <= {WIDTH{1'b0}};
            r_lo     <= i_mag_a;
            r_b      <= i_mag_b;
            r_cnt    <= {CW{1'b0}};
            r_is_div <= i_is_div;
            r_neg    <= i_neg;
        end else if (i_busy) begin
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_cnt    <= r_cnt + CW'(1);
        end else begin
            r_cnt    <= r_cnt;
        end
    end

endmodule

// File: rtl/multdiv_exception_unit.sv
// Iterative mul/div beside the X stage: stalls the front end, then emits a result (rstatus on exception).
// Optional MULTDIV_EARLY_OUT_EN: zero mul operand or zero divisor skips the iterations.
module multdiv_exception_unit
    import proc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      DXIR,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             stall,
    output logic             md_valid,
    output logic [31:0]      md_IR,
    output logic [WIDTH-1:0] md_O
);

    md_state_e          r_state;
    md_state_e          w_state_nxt;

    logic               w_is_md;
    logic               w_is_div_in;
    logic               w_b_zero_in;
    logic               w_early;
    logic               w_start;
    logic               w_done_step;
    logic               w_take_result;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_neg;
    logic [2*WIDTH-1:0] w_product;

    logic [31:0]        r_ir;
    logic               r_is_div;
    logic               r_b_zero;

    logic [31:0]        w_src_ir;
    logic               w_src_div;
    logic               w_src_bz;
    logic [2*WIDTH-1:0] w_src_val;
    logic [WIDTH:0]     w_upper;
    logic               w_exc;
    logic [31:0]        w_res_ir;
    logic [WIDTH-1:0]   w_res_o;

    assign w_is_md     = f_is_md(DXIR);
    assign w_is_div_in = (DXIR[6:2] == ALUOP_DIV);
    assign w_b_zero_in = (operandB == {WIDTH{1'b0}});
    assign w_mag_a     = operandA[WIDTH-1] ? ({WIDTH{1'b0}} - operandA) : operandA;
    assign w_mag_b     = operandB[WIDTH-1] ? ({WIDTH{1'b0}} - operandB) : operandB;
    assign w_neg       = operandA[WIDTH-1] ^ operandB[WIDTH-1];

`ifdef MULTDIV_EARLY_OUT_EN
    assign w_early = w_is_div_in ? w_b_zero_in
                                 : ((operandA == {WIDTH{1'b0}}) || w_b_zero_in);
`else
    assign w_early = 1'b0;
`endif

    multdiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clock       (clock),
        .reset       (reset),
        .i_start     (w_start),
        .i_busy      (r_state == BUSY),
        .i_is_div    (w_is_div_in),
        .i_mag_a     (w_mag_a),
        .i_mag_b     (w_mag_b),
        .i_neg       (w_neg),
        .o_done_step (w_done_step),
        .o_result    (w_product)
    );

    // Next-state and stall decode
    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                stall = w_is_md;
                if (w_is_md) begin
                    w_start     = 1'b1;
                    w_state_nxt = w_early ? DONE : BUSY;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (w_done_step) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = BUSY;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Instruction context captured when the operation starts
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ir     <= 32'd0;
            r_is_div <= 1'b0;
            r_b_zero <= 1'b0;
        end else if (w_start) begin
            r_ir     <= DXIR;
            r_is_div <= w_is_div_in;
            r_b_zero <= w_b_zero_in;
        end else begin
            r_ir     <= r_ir;
        end
    end

    // Early-out results come straight from DX (product is zero); otherwise from the datapath
    always_comb begin
        if (r_state == IDLE) begin
            w_src_ir  = DXIR;
            w_src_div = w_is_div_in;
            w_src_bz  = w_b_zero_in;
            w_src_val = {(2*WIDTH){1'b0}};
        end else begin
            w_src_ir  = r_ir;
            w_src_div = r_is_div;
            w_src_bz  = r_b_zero;
            w_src_val = w_product;
        end
        w_upper  = w_src_val[2*WIDTH-1:WIDTH-1];
        w_exc    = w_src_div ? w_src_bz : !((&w_upper) || (~|w_upper));
        w_res_ir = w_src_ir;
        w_res_o  = w_src_val[WIDTH-1:0];
        if (w_exc) begin
            w_res_ir[26:22] = RSTATUS_REG;
            w_res_o = w_src_div ? WIDTH'(DIV_EXC_CODE) : WIDTH'(MUL_EXC_CODE);
        end else if (w_src_ir[26:22] == 5'd0) begin
            w_res_o = {WIDTH{1'b0}};
        end else begin
            w_res_o = w_src_val[WIDTH-1:0];
        end
    end

    assign w_take_result = ((r_state == IDLE) && w_is_md && w_early) ||
                           ((r_state == BUSY) && w_done_step);

    // Result registers: pulse valid for the DONE cycle, hold values otherwise
    always_ff @(posedge clock) begin
        if (reset) begin
            md_valid <= 1'b0;
            md_IR    <= 32'd0;
            md_O     <= {WIDTH{1'b0}};
        end else if (w_take_result) begin
            md_valid <= 1'b1;
            md_IR    <= w_res_ir;
            md_O     <= w_res_o;
        end else begin
            md_valid <= 1'b0;
        end
    end

endmodule

// File: doc/multdiv_exception_unit.md
Name: multdiv_exception_unit

Overview:
- Iterative multiply/divide unit for ALU R-type `mul` (aluop 6) and `div` (aluop 7).
- The DX-stage exception path passes these two aluops through as a zeroed instruction, so this block produces their results instead.
- Sits beside the X stage. It stalls the front of the pipeline while busy, then emits a result instruction and value for X/M.
- On exception it rewrites rd to $30 (rstatus) and the value to the exception code: 4 for mul overflow, 5 for div by zero. This matches the rstatus convention used for add/sub/addi (codes 1/3/2).

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.
- RSTATUS_REG, 30, register index written on exception.
- MUL_EXC_CODE, 4, rstatus value on mul overflow.
- DIV_EXC_CODE, 5, rstatus value on div by zero.

Ports:
- clock  input  1  Single clock. All state changes on the rising edge.
- reset  input  1  Synchronous, active-high.
- DXIR  input  32  Instruction in the DX latch. Held stable by the pipeline while stall=1.
- operandA  input  32  rs value after bypass.
- operandB  input  32  rt value after bypass.
- stall  output  1  Freezes F/D/DX latches and inserts a nop into X/M.
- md_valid  output  1  One-cycle pulse: md_IR/md_O are valid and the X/M mux selects them.
- md_IR  output  32  Result instruction for X/M (rd possibly rewritten).
- md_O  output  32  Result value for X/M.

Behaviour:
- Decode: `is_md = (DXIR[31:27]==0) && (DXIR[6:2]==6 || DXIR[6:2]==7)`.
- States: IDLE, BUSY, DONE.
- IDLE:
  - stall = is_md (combinational).
  - If is_md, latch opcode, rd, sign-corrected magnitudes of A and B, and the result sign; counter=0; go to BUSY.
- BUSY:
  - stall=1. One shift-add (mul) or restoring-subtract (div) step per cycle.
  - After WIDTH steps (counter==WIDTH-1) go to DONE.
- DONE:
  - stall=0, md_valid=1; outputs driven from registers; next state IDLE.
  - The pipeline advances this cycle, so the instruction cannot re-trigger.
- Latency: WIDTH+2 cycles from is_md seen in IDLE to md_valid. For WIDTH=32 that is stall high for 33 cycles and md_valid in cycle 34.
- Back-to-back md instructions: the second is seen in IDLE the cycle after DONE and restarts normally.
- Arithmetic (signed two's complement):
  - mul: 2*WIDTH-bit product. Overflow when product[63:31] is not all-0 and not all-1.
  - div: quotient truncates toward zero. Divisor==0 is an exception. INT_MIN / -1 returns INT_MIN with no exception.
- Result rules:
  - exception: md_IR = DXIR with [26:22] replaced by RSTATUS_REG; md_O = the code.
  - otherwise: md_IR = latched DXIR; md_O = low WIDTH bits of the product or the quotient.
  - rd==0 with no exception: md_O = 0.
- Reset (in any state, including mid-BUSY):
  - state=IDLE, counter=0, md_valid=0, md_IR=0, md_O=0.
  - stall follows the IDLE rule on the next cycle.
- md_IR and md_O hold their last values outside DONE; consumers must qualify them with md_valid.

Optional Feature:
- Macro: MULTDIV_EARLY_OUT_EN.
- Defined:
  - Divisor==0, or either mul operand==0, goes IDLE->DONE directly.
  - Latency is 2 cycles: stall for 1 cycle, md_valid in cycle 2.
  - Results are identical to the full-latency path (exception code 5; mul product 0).
- Not defined: every md instruction takes WIDTH+2 cycles.

Decomposition:
- Shared package `proc_pkg`:
  - OPC_RTYPE=5'd0, ALUOP_MUL=5'd6, ALUOP_DIV=5'd7.
  - RSTATUS_REG, MUL_EXC_CODE, DIV_EXC_CODE.
  - The state enum {IDLE, BUSY, DONE}.
  - Reuse the existing add/sub/addi codes 1/3/2 from the same package.
- One sub-module, `multdiv_datapath`:
  - Holds the shared accumulator/remainder, shift register and counter.
  - Inputs: start, is_div, magnitudes.
  - Outputs: done_step, raw product/quotient, sign fix-up.
- The FSM and result rewrite stay in the top module.

Test Plan:
- mul $5,$2,$3 with A=7, B=-6 -> stall 33 cycles; md_valid with md_O=0xFFFFFFD6 (-42); md_IR rd=5.
- mul with A=0x10000, B=0x10000 -> md_valid with md_IR[26:22]=30, md_O=4.
- div $4,$1,$2 with A=-7, B=2 -> md_O=0xFFFFFFFD (-3). Then div with B=0 -> rd=30, md_O=5. With MULTDIV_EARLY_OUT_EN the div-by-zero case asserts md_valid in cycle 2.
- mul with rd=0, A=3, B=4 -> md_O=0, md_IR unchanged. div INT_MIN/-1 -> md_O=0x80000000, no rd rewrite.
- Two consecutive muls -> stall drops for exactly the single DONE cycle, then reasserts; two md_valid pulses, 34 cycles apart.
- reset asserted at BUSY counter=10 -> next cycle state IDLE, md_valid=0, md_O=0, md_IR=0; the held md instruction restarts from counter 0 after reset is released.
